// File: rtl/dmem_ctrl_pkg.sv
// Shared types, funct3 size codes and legality check for the data-memory controller.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package dmem_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_e;

   // RV32 funct3 encodings for load/store width
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // Size/alignment legality. Only the low address bits matter here; the range
   // check depends on the memory size parameter and is done in the controller.
   function automatic logic is_legal(input logic [2:0] size,
                                     input logic       we,
                                     input logic [1:0] addr);
      logic ok;
      case (size)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = ~addr[0];
         SZ_W:    ok = (addr == 2'b00);
         SZ_BU:   ok = ~we;
         SZ_HU:   ok = ~we & ~addr[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: word (memory word), addr (byte offset), size (funct3), wdata (right-justified
//        store data) -> ext_rdata (extended load value), merged_wdata (word to write back).
module dmem_lane_align
   import dmem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] ext_rdata,
   output logic [31:0] merged_wdata
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word[{addr, 3'b000} +: 8];
      half_v = addr[1] ? word[31:16] : word[15:0];

      ext_rdata = 32'h0;
      case (size)
         SZ_B:    ext_rdata = {{24{byte_v[7]}}, byte_v};
         SZ_BU:   ext_rdata = {24'h0, byte_v};
         SZ_H:    ext_rdata = {{16{half_v[15]}}, half_v};
         SZ_HU:   ext_rdata = {16'h0, half_v};
         SZ_W:    ext_rdata = word;
         default: ext_rdata = 32'h0;
      endcase

      // Only the addressed lane is replaced; the rest keeps the value just read.
      merged_wdata = word;
      case (size)
         SZ_B:    merged_wdata[{addr, 3'b000} +: 8]    = wdata[7:0];
         SZ_H:    merged_wdata[{addr[1], 4'b0000} +: 16] = wdata[15:0];
         SZ_W:    merged_wdata = wdata;
         default: merged_wdata = word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Round-robin arbiter and load/store sequencer in front of a word-wide data memory.
// Latency: accept->rsp 1 cycle (error), 2 (sw), 3 (load), 4 (sb/sh read-modify-write).
// Backpressure: one transaction at a time; requesters hold req_valid until req_ready.
// Ports: clk, rst_n; per-requester req_valid/we/size/addr/wdata packed NREQ-wide and
//        req_ready/rsp_valid one-hot; shared rsp_rdata/rsp_err; memory read/write/addr/
//        wdata outputs with mem_rdata returned the cycle after mem_read.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int MEM_BYTES = 2048
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*3-1:0]    req_size,
   input  logic [NREQ*32-1:0]   req_addr,
   input  logic [NREQ*32-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_err,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);

   localparam int PW = (NREQ > 2) ? 2 : 1;

   state_e          state_q, state_d;
   logic [PW-1:0]   rr_q;
   logic [PW-1:0]   own_q;
   logic            we_q;
   logic [2:0]      size_q;
   logic [31:0]     addr_q;
   logic [31:0]     dat_q;    // store data at accept, then read/merged word
   logic            err_q;

   logic [2:0]      sz_a   [NREQ];
   logic [31:0]     addr_a [NREQ];
   logic [31:0]     wdat_a [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign sz_a[i]   = req_size[i*3 +: 3];
      assign addr_a[i] = req_addr[i*32 +: 32];
      assign wdat_a[i] = req_wdata[i*32 +: 32];
   end

   // Round-robin pick: lowest valid index at or above the pointer, else lowest overall.
   logic            gnt_vld;
   logic [PW-1:0]   gnt_idx;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(i);
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i >= int'(rr_q))) begin
            gnt_idx = PW'(i);
         end
      end
   end

   logic            sel_we;
   logic [2:0]      sel_size;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic            sel_err;
   logic            accept;

   assign sel_we    = req_we[gnt_idx];
   assign sel_size  = sz_a[gnt_idx];
   assign sel_addr  = addr_a[gnt_idx];
   assign sel_wdata = wdat_a[gnt_idx];
   assign sel_err   = !is_legal(sel_size, sel_we, sel_addr[1:0]) ||
                      (sel_addr >= 32'(MEM_BYTES));
   // rst_n gates the grant so req_ready stays low while reset is held.
   assign accept    = rst_n && (state_q == IDLE) && gnt_vld;

   logic [31:0]     ext_rdata;
   logic [31:0]     merged_wdata;

   dmem_lane_align u_align (
      .word         (mem_rdata),
      .addr         (addr_q[1:0]),
      .size         (size_q),
      .wdata        (dat_q),
      .ext_rdata    (ext_rdata),
      .merged_wdata (merged_wdata)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      rsp_rdata = 32'h0;
      rsp_err   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               req_ready[gnt_idx] = 1'b1;
               if (sel_err)
                  state_d = RESP;
               else if (sel_we && (sel_size == SZ_W))
                  state_d = WRITE;
               else
                  state_d = READ;
            end
         end
         READ: begin
            mem_read = 1'b1;
            mem_addr = {addr_q[31:2], 2'b00};
            state_d  = WAIT;
         end
         WAIT: begin
            state_d = we_q ? WRITE : RESP;
         end
         WRITE: begin
            mem_write = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00};
            mem_wdata = dat_q;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid[own_q] = 1'b1;
            rsp_err          = err_q;
            rsp_rdata        = (we_q || err_q) ? 32'h0 : dat_q;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q   <= '0;
         own_q  <= '0;
         we_q   <= 1'b0;
         size_q <= 3'b000;
         addr_q <= 32'h0;
         dat_q  <= 32'h0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            rr_q   <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            own_q  <= gnt_idx;
            we_q   <= sel_we;
            size_q <= sel_size;
            addr_q <= sel_addr;
            dat_q  <= sel_wdata;
            err_q  <= sel_err;
         end else if (state_q == WAIT) begin
            dat_q <= we_q ? merged_wdata : ext_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
   logic [5:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        rsp_err, mem_read, mem_write;

   int checks = 0;
   int failures = 0;

   dmem_ctrl #(.NREQ(2), .MEM_BYTES(2048)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: synchronous write, registered read data.
   logic [31:0] mem [512];
   int wr_count = 0;
   int overlap  = 0;
   always @(posedge clk) begin
      if (mem_write) begin
         mem[mem_addr[10:2]] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
      if (mem_read) mem_rdata <= mem[mem_addr[10:2]];
      if (mem_read && mem_write) overlap <= overlap + 1;
   end

   // Trace of the last transaction, cycles counted from accept (C0).
   int          n_rd, n_wr, rd_cyc, wr_cyc, rsp_cyc;
   logic [31:0] rd_addr, wr_addr, wr_dat, rsp_d;
   logic [1:0]  rsp_vec;
   logic        rsp_e;

   task automatic xact(input int idx, input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
      int c;
      req_we[idx]            = we;
      req_size[idx*3 +: 3]   = sz;
      req_addr[idx*32 +: 32] = a;
      req_wdata[idx*32 +: 32] = wd;
      req_valid[idx]         = 1'b1;
      c = 0;
      @(negedge clk);
      while (!req_ready[idx] && c < 20) begin
         c++;
         @(negedge clk);
      end
      if (!req_ready[idx]) begin
         checks++; failures++;
         $display("FAIL accept_timeout req=%0d addr=%h ready=%b required one-hot grant", idx, a, req_ready);
      end
      @(posedge clk); #1;
      req_valid[idx]          = 1'b0;
      req_addr[idx*32 +: 32]  = 32'hFFFF_FFFF;
      req_size[idx*3 +: 3]    = 3'b111;
      req_wdata[idx*32 +: 32] = ~wd;
      req_we[idx]             = ~we;
      n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0; rsp_cyc = 0;
      rd_addr = 0; wr_addr = 0; wr_dat = 0; rsp_d = 0; rsp_vec = 0; rsp_e = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (mem_read)  begin n_rd++; rd_cyc = k; rd_addr = mem_addr; end
         if (mem_write) begin n_wr++; wr_cyc = k; wr_addr = mem_addr; wr_dat = mem_wdata; end
         if (rsp_valid != 2'b00) begin
            rsp_cyc = k; rsp_vec = rsp_valid; rsp_e = rsp_err; rsp_d = rsp_rdata;
            break;
         end
      end
      if (rsp_cyc == 0) begin
         checks++; failures++;
         $display("FAIL rsp_timeout req=%0d addr=%h no rsp_valid within 8 cycles", idx, a);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req_we = 2'b00;
      req_size = {SZ_W, SZ_W};
      req_addr = {32'h4, 32'h0};
      req_wdata = 64'h0;
      req_valid = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
          mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs ready=%b rsp=%b err=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h required all 0",
                  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata);
      end
      #2 rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL first_grant ready=%b required 01", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (6) @(posedge clk);
   endtask

   task automatic test_word;
      xact(0, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF);
      checks++;
      if (n_wr !== 1 || wr_cyc !== 1 || n_rd !== 0 || wr_addr !== 32'h10 || wr_dat !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL sw_write n_wr=%0d cyc=%0d n_rd=%0d addr=%h data=%h required 1/1/0/00000010/deadbeef",
                  n_wr, wr_cyc, n_rd, wr_addr, wr_dat);
      end
      checks++;
      if (rsp_cyc !== 2 || rsp_vec !== 2'b01 || rsp_e !== 1'b0 || rsp_d !== 32'h0) begin
         failures++;
         $display("FAIL sw_rsp cyc=%0d vec=%b err=%b data=%h required 2/01/0/0", rsp_cyc, rsp_vec, rsp_e, rsp_d);
      end
      xact(0, 1'b0, SZ_W, 32'h10, 32'h0);
      checks++;
      if (n_rd !== 1 || rd_cyc !== 1 || n_wr !== 0 || rd_addr !== 32'h10) begin
         failures++;
         $display("FAIL lw_read n_rd=%0d cyc=%0d n_wr=%0d addr=%h required 1/1/0/00000010", n_rd, rd_cyc, n_wr, rd_addr);
      end
      checks++;
      if (rsp_cyc !== 3 || rsp_vec !== 2'b01 || rsp_e !== 1'b0 || rsp_d !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL lw_rsp cyc=%0d vec=%b err=%b data=%h required 3/01/0/deadbeef", rsp_cyc, rsp_vec, rsp_e, rsp_d);
      end
   endtask

   task automatic test_subword;
      logic [2:0]  sz  [5] = '{SZ_B, SZ_BU, SZ_HU, SZ_H, SZ_B};
      logic [31:0] ad  [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
      logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AD, 32'hFFFF_80AD, 32'hFFFF_FFEF};
      // Upper wdata bits must be ignored for a byte store.
      xact(0, 1'b1, SZ_B, 32'h13, 32'h1234_5680);
      checks++;
      if (n_rd !== 1 || rd_cyc !== 1 || n_wr !== 1 || wr_cyc !== 3 || wr_addr !== 32'h10 ||
          wr_dat !== 32'h80AD_BEEF || rsp_cyc !== 4 || rsp_e !== 1'b0) begin
         failures++;
         $display("FAIL sb_rmw rd=%0d@%0d wr=%0d@%0d addr=%h data=%h rsp@%0d err=%b required 1@1 1@3 00000010 80adbeef rsp@4 0",
                  n_rd, rd_cyc, n_wr, wr_cyc, wr_addr, wr_dat, rsp_cyc, rsp_e);
      end
      for (int i = 0; i < 5; i++) begin
         xact(0, 1'b0, sz[i], ad[i], 32'h0);
         checks++;
         if (rsp_cyc !== 3 || rsp_e !== 1'b0 || rsp_d !== exp[i] || n_wr !== 0) begin
            failures++;
            $display("FAIL subword_load%0d size=%b addr=%h cyc=%0d err=%b data=%h required 3/0/%h",
                     i, sz[i], ad[i], rsp_cyc, rsp_e, rsp_d, exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0]  gseq [4];
      logic [1:0]  rseq [4];
      logic [31:0] rdat [4];
      logic [1:0]  exp_oh [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      logic [31:0] exp_d  [4] = '{32'h80AD_BEEF, 32'h55AA_33CC, 32'h80AD_BEEF, 32'h55AA_33CC};
      int ng, nr;
      // Grant to req1 leaves the pointer at 0.
      xact(1, 1'b1, SZ_W, 32'h14, 32'h55AA_33CC);
      checks++;
      if (wr_addr !== 32'h14 || wr_dat !== 32'h55AA_33CC || rsp_vec !== 2'b10) begin
         failures++;
         $display("FAIL req1_sw addr=%h data=%h vec=%b required 00000014/55aa33cc/10", wr_addr, wr_dat, rsp_vec);
      end
      req_we = 2'b00;
      req_size = {SZ_W, SZ_W};
      req_addr = {32'h14, 32'h10};
      req_valid = 2'b11;
      ng = 0; nr = 0;
      for (int k = 0; k < 40 && nr < 4; k++) begin
         @(negedge clk);
         if (req_ready != 2'b00 && ng < 4) begin gseq[ng] = req_ready; ng++; end
         if (rsp_valid != 2'b00) begin rseq[nr] = rsp_valid; rdat[nr] = rsp_rdata; nr++; end
      end
      req_valid = 2'b00;
      checks++;
      if (ng !== 4 || nr !== 4) begin
         failures++;
         $display("FAIL b2b_count grants=%0d rsps=%0d required 4/4", ng, nr);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (gseq[i] !== exp_oh[i] || rseq[i] !== exp_oh[i] || rdat[i] !== exp_d[i]) begin
               failures++;
               $display("FAIL b2b_%0d grant=%b rsp=%b data=%h required %b/%b/%h",
                        i, gseq[i], rseq[i], rdat[i], exp_oh[i], exp_oh[i], exp_d[i]);
            end
         end
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_errors;
      logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0]  sz [4] = '{SZ_H, SZ_W, 3'b011, SZ_W};
      logic [31:0] ad [4] = '{32'h11, 32'h802, 32'h0, 32'h800};
      for (int i = 0; i < 4; i++) begin
         xact(0, we[i], sz[i], ad[i], 32'hA5A5_A5A5);
         checks++;
         if (rsp_cyc !== 1 || rsp_e !== 1'b1 || rsp_d !== 32'h0 || n_rd !== 0 || n_wr !== 0 || rsp_vec !== 2'b01) begin
            failures++;
            $display("FAIL err_%0d size=%b addr=%h cyc=%0d err=%b data=%h rd=%0d wr=%0d vec=%b required 1/1/0/0/0/01",
                     i, sz[i], ad[i], rsp_cyc, rsp_e, rsp_d, n_rd, n_wr, rsp_vec);
         end
      end
   endtask

   task automatic test_reset_midflight;
      int wc;
      xact(0, 1'b1, SZ_W, 32'h20, 32'hCAFE_F00D);
      req_we[0] = 1'b1;
      req_size[2:0] = SZ_H;
      req_addr[31:0] = 32'h20;
      req_wdata[31:0] = 32'h1234;
      req_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin
         failures++;
         $display("FAIL sh_accept ready=%b required 01", req_ready);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_read !== 1'b1) begin
         failures++;
         $display("FAIL sh_read mem_read=%b required 1", mem_read);
      end
      @(posedge clk); #2;            // inside WAIT
      wc = wr_count;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL midreset_outputs wr=%b rd=%b addr=%h wdata=%h rsp=%b ready=%b required all 0",
                  mem_write, mem_read, mem_addr, mem_wdata, rsp_valid, req_ready);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      checks++;
      if (wr_count !== wc) begin
         failures++;
         $display("FAIL midreset_nowrite writes=%0d required %0d", wr_count, wc);
      end
      xact(0, 1'b0, SZ_W, 32'h20, 32'h0);
      checks++;
      if (rsp_d !== 32'hCAFE_F00D || rsp_e !== 1'b0 || rsp_cyc !== 3) begin
         failures++;
         $display("FAIL midreset_word data=%h err=%b cyc=%0d required cafef00d/0/3", rsp_d, rsp_e, rsp_cyc);
      end
   endtask

   initial begin
      req_valid = 2'b00;
      test_reset;
      test_word;
      test_subword;
      test_back_to_back;
      test_errors;
      test_reset_midflight;
      checks++;
      if (overlap !== 0) begin
         failures++;
         $display("FAIL rd_wr_overlap cycles=%0d required 0", overlap);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Controller and arbiter in front of the single-cycle core's byte-addressed data memory.
- Shares the memory between NREQ requesters: index 0 is the core LSU, index 1 is the debug/loader port.
- Converts RV32 load/store sizes into word-aligned memory accesses.
  - Sub-word stores use read-modify-write.
  - Loads are sign- or zero-extended.
  - Misaligned and out-of-range accesses return an error without touching memory.

Parameters:
NREQ, 2, number of requesters (2..4)
MEM_BYTES, 2048, memory size in bytes; valid addresses are 0..MEM_BYTES-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending; held with its fields until accepted
req_we  in  NREQ  1 = store, 0 = load
req_size  in  NREQ x 3  funct3 encoding
req_addr  in  NREQ x 32  byte address
req_wdata  in  NREQ x 32  store data, right-justified
req_ready  out  NREQ  one-hot, 1-cycle acceptance pulse
rsp_valid  out  NREQ  one-hot, 1-cycle completion pulse to the owning requester
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualifies rsp_valid: misaligned, out-of-range or illegal size
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_addr  out  32  always word-aligned: {addr[31:2],2'b00}
mem_wdata  out  32  full word to write
mem_rdata  in  32  memory data, valid the cycle after mem_read

Behaviour:
- Reset:
  - Asynchronous; takes effect immediately on rst_n low.
  - FSM goes to IDLE, RR pointer to 0.
  - All outputs go to 0, including mem_write; any in-flight transaction is abandoned and never written.
- FSM states: IDLE, READ, WAIT, WRITE, RESP. Requests are accepted only in IDLE.
- Arbitration:
  - Round-robin among asserted req_valid, starting at the pointer.
  - On grant to i: pulse req_ready[i], register the request, set pointer = (i+1) mod NREQ.
  - With no requests, stay in IDLE and drive no outputs.
- Legal sizes:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
- Errors: illegal size; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES.
  - Error sequence: accept -> RESP, so rsp_err=1 one cycle after accept.
  - No mem_read or mem_write is issued.
- Load sequence, accept at C0:
  - C1 READ: mem_read=1.
  - C2 WAIT: latch the extracted lane from mem_rdata.
  - C3 RESP: rsp_valid.
- Word store: C1 WRITE (mem_write=1, mem_wdata=wdata) -> C2 RESP.
- Sub-word store:
  - C1 READ, C2 WAIT: merge the wdata byte/half into the latched word at addr[1:0].
  - C3 WRITE merged word -> C4 RESP.
- Lane select:
  - Bytes use addr[1:0].
  - Halves use addr[1]: 0 selects bits [15:0], 1 selects bits [31:16].
  - Sign-extend for lb/lh; zero-extend for lbu/lhu.
- Output timing:
  - mem_read and mem_write are single-cycle pulses, never asserted together.
  - mem_addr and mem_wdata are valid only while mem_read or mem_write is high, and 0 otherwise.
- RESP returns to IDLE. A new grant is possible on the cycle after RESP.
- Requester fields are don't-care after acceptance; the controller uses its registered copies.

Decomposition:
- Package dmem_ctrl_pkg:
  - state_e enum.
  - funct3 localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - Functions: is_legal(size, we, addr).
- Sub-module dmem_lane_align, purely combinational:
  - Inputs: word, addr[1:0], size, wdata.
  - Outputs: ext_rdata and merged_wdata.
- FSM and arbiter live in dmem_ctrl.

Test Plan:
1. Hold rst_n=0, all req_valid high -> all outputs 0. Release -> first grant goes to req 0.
2. Req0 sw 0xDEADBEEF @0x10, then lw @0x10 -> exactly one mem_write at C1 with addr 0x10; load rsp_rdata=0xDEADBEEF at C3, rsp_err=0.
3. Req0 sb 0x80 @0x13 -> mem_read C1, mem_write C3 with 0x80ADBEEF, rsp C4. Then lb @0x13 -> 0xFFFFFF80; lbu -> 0x00000080; lhu @0x12 -> 0x000080AD.
4. Both valid every cycle -> grants alternate 0,1,0,1. rsp_valid bit matches the granted index each time.
5. lh @0x11, lw @0x802, size 011 -> rsp_err=1 one cycle after accept, no mem_read/mem_write, rsp_rdata=0.
6. sh 0x1234 @0x20 with rst_n pulsed low during WAIT -> no mem_write, outputs 0 immediately. Word @0x20 unchanged on a later lw.
